// File: rtl/multicycle_datapath.sv
// multicycle_datapath: MIPS-subset core with a FETCH/DECODE/EXEC/MEM/WB
// sequencer sharing one memory port for instructions and data.
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              retire,
  output logic              halt
);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  state_t state, state_nx;

  logic [31:0] pc, ir, a, b;
  logic [31:0] alu_out, mdr;
  logic [31:0] regs [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, wdst;
  logic [31:0] imm_sx, alu_b, alu_y, wval;
  logic        is_r, is_alu, is_jr;
  logic        is_addi, is_lw, is_sw;
  logic        is_beq, is_j, legal;

  assign op     = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign imm_sx = {{16{ir[15]}}, ir[15:0]};

  assign is_r    = op == 6'h00;
  assign is_alu  = is_r && (funct == 6'h20 ||
                   funct == 6'h22 || funct == 6'h24 ||
                   funct == 6'h25 || funct == 6'h2A);
  assign is_jr   = is_r && funct == 6'h08;
  assign is_addi = op == 6'h08;
  assign is_lw   = op == 6'h23;
  assign is_sw   = op == 6'h2B;
  assign is_beq  = op == 6'h04;
  assign is_j    = op == 6'h02;
  assign legal   = is_alu | is_jr | is_addi |
                   is_lw | is_sw | is_beq | is_j;

  assign alu_b = is_r ? b : imm_sx;
  assign wdst  = is_r ? rd : rt;
  assign wval  = is_lw ? mdr : alu_out;

  // funct is only meaningful for R-type; immediates always add
  always_comb begin
    alu_y = a + alu_b;
    if (is_r) begin
      case (funct)
        6'h22:   alu_y = a - alu_b;
        6'h24:   alu_y = a & alu_b;
        6'h25:   alu_y = a | alu_b;
        6'h2A:   alu_y = {31'b0,
                   $signed(a) < $signed(alu_b)};
        default: alu_y = a + alu_b;
      endcase
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc[ADDR_W-1:0];
    mem_wdata = b;
    retire    = 1'b0;
    halt      = state == HALT;
    if (!rst) begin
      unique case (state)
        FETCH: mem_req = 1'b1;
        EXEC:  retire  = is_beq | is_j | is_jr;
        MEM: begin
          mem_req  = 1'b1;
          mem_we   = is_sw;
          mem_addr = alu_out[ADDR_W-1:0];
          retire   = is_sw & mem_ready;
        end
        WB:      retire = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FETCH:
        if (mem_ready) state_nx = DECODE;
      DECODE:
        state_nx = legal ? EXEC : HALT;
      EXEC: begin
        unique case (1'b1)
          is_alu, is_addi: state_nx = WB;
          is_lw, is_sw:    state_nx = MEM;
          default:         state_nx = FETCH;
        endcase
      end
      MEM:
        if (mem_ready)
          state_nx = is_lw ? WB : FETCH;
      WB:      state_nx = FETCH;
      HALT:    state_nx = HALT;
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        FETCH:
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + 32'd4;
          end
        DECODE: begin
          a <= regs[rs];
          b <= regs[rt];
        end
        EXEC: begin
          if (is_alu | is_addi | is_lw | is_sw)
            alu_out <= alu_y;
          if (is_beq && a == b)
            pc <= pc + (imm_sx << 2);
          if (is_j)
            pc <= {pc[31:28], ir[25:0], 2'b00};
          if (is_jr)
            pc <= a;
        end
        MEM:
          if (mem_ready && is_lw) mdr <= mem_rdata;
        WB:
          // reg 0 is never written, so it always reads 0
          if (wdst != 5'd0) regs[wdst] <= wval;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: directed programs run against a
// behavioural unified memory with configurable wait states.
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_we, mem_ready;
  logic        retire, halt;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  multicycle_datapath #(
    .RESET_PC(32'h100),
    .ADDR_W  (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .retire   (retire),
    .halt     (halt)
  );

  logic [31:0] mem [0:1023];
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  bit          clr = 1'b0;
  bit          ld = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data = '0;

  int          cyc = 0;
  int          ret_n = 0;
  int          ret_log [64];
  int          fetch_n = 0;
  logic [31:0] fetch_log [64];
  int          wr_n = 0;
  logic [31:0] wr_addr0, wr_data0;
  int          viol = 0;
  bit          pend = 1'b0;
  logic [31:0] p_addr, p_wdata;
  logic        p_we;

  int n_pass = 0;
  int n_checks = 0;

  assign mem_ready = mem_req && (wait_cnt >= wait_cfg);
  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      ret_n   <= 0;
      fetch_n <= 0;
      wr_n    <= 0;
      viol    <= 0;
    end else begin
      if (ld) mem[ld_addr[11:2]] <= ld_data;
      if (mem_req && mem_ready && mem_we) begin
        mem[mem_addr[11:2]] <= mem_wdata;
        if (wr_n == 0) begin
          wr_addr0 <= mem_addr;
          wr_data0 <= mem_wdata;
        end
        wr_n <= wr_n + 1;
      end
      if (mem_req && mem_ready && !mem_we
          && fetch_n < 64) begin
        fetch_log[fetch_n] <= mem_addr;
        fetch_n <= fetch_n + 1;
      end
      if (retire && ret_n < 64) begin
        ret_log[ret_n] <= cyc + 1;
        ret_n <= ret_n + 1;
      end
      if (pend && !rst && !(mem_req
          && mem_addr == p_addr && mem_we == p_we
          && (!p_we || mem_wdata == p_wdata)))
        viol <= viol + 1;
    end
    cyc      <= rst ? 0 : cyc + 1;
    wait_cnt <= (mem_req && !mem_ready) ?
                wait_cnt + 1 : 0;
    pend     <= mem_req && !mem_ready;
    p_addr   <= mem_addr;
    p_we     <= mem_we;
    p_wdata  <= mem_wdata;
  end

  task automatic start(input int w);
    rst = 1'b1;
    wait_cfg = w;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic load(input logic [31:0] a,
                      input logic [31:0] d);
    ld_addr = a;
    ld_data = d;
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic run_until_halt(input int budget,
                                output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (halt) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    start(0);
    #1;
    n_checks++;
    if (mem_req !== 1'b0)
      $display("FAIL rst_req: got %b want 0", mem_req);
    else n_pass++;
    n_checks++;
    if (retire !== 1'b0 || halt !== 1'b0)
      $display("FAIL rst_outs: got ret=%b halt=%b want 0 0",
               retire, halt);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0)
      $display("FAIL first_fetch: got req=%b we=%b want 1 0",
               mem_req, mem_we);
    else n_pass++;
    n_checks++;
    if (mem_addr !== 32'h100)
      $display("FAIL first_addr: got %h want 00000100",
               mem_addr);
    else n_pass++;
    run_until_halt(20, ok);
    n_checks++;
    if (!ok || mem_req !== 1'b0)
      $display("FAIL zero_word_halt: got halt=%b req=%b want 1 0",
               halt, mem_req);
    else n_pass++;
  endtask

  task automatic test_alu();
    bit ok;
    logic [31:0] prog [14];
    logic [31:0] exp [6];
    prog = '{32'h20010005, 32'h2002FFFD, 32'h00221820,
             32'h0041202A, 32'h00222822, 32'h00223024,
             32'h00223825, 32'h0022402A, 32'hAC030300,
             32'hAC040304, 32'hAC050308, 32'hAC06030C,
             32'hAC070310, 32'hAC080314};
    exp = '{32'd2, 32'd1, 32'd8, 32'd5,
            32'hFFFFFFFD, 32'd0};
    start(0);
    for (int i = 0; i < 14; i++)
      load(32'h100 + 32'(4 * i), prog[i]);
    load(32'h100 + 32'd56, 32'hFC000000);
    rst = 1'b0;
    run_until_halt(200, ok);
    n_checks++;
    if (!ok) $display("FAIL alu_halt: got 0 want 1");
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ret_log[i] !== 4 * (i + 1))
        $display("FAIL alu_retire%0d: got %0d want %0d",
                 i, ret_log[i], 4 * (i + 1));
      else n_pass++;
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (mem[192 + i] !== exp[i])
        $display("FAIL alu_res%0d: got %h want %h",
                 i, mem[192 + i], exp[i]);
      else n_pass++;
    end
    n_checks++;
    if (ret_n !== 14)
      $display("FAIL alu_count: got %0d want 14", ret_n);
    else n_pass++;
  endtask

  task automatic test_mem_wait();
    bit ok;
    start(2);
    load(32'h100, 32'h20010005);
    load(32'h104, 32'hAC010008);
    load(32'h108, 32'h8C050008);
    load(32'h10C, 32'hAC050300);
    load(32'h110, 32'hFC000000);
    rst = 1'b0;
    run_until_halt(200, ok);
    n_checks++;
    if (!ok) $display("FAIL mem_halt: got 0 want 1");
    else n_pass++;
    n_checks++;
    if (wr_addr0 !== 32'd8 || wr_data0 !== 32'd5)
      $display("FAIL sw_write: got %h/%h want 8/5",
               wr_addr0, wr_data0);
    else n_pass++;
    n_checks++;
    if (mem[192] !== 32'd5)
      $display("FAIL lw_value: got %h want 5", mem[192]);
    else n_pass++;
    n_checks++;
    if (ret_log[0] !== 6)
      $display("FAIL addi_wait: got %0d want 6", ret_log[0]);
    else n_pass++;
    n_checks++;
    if (ret_log[1] - ret_log[0] !== 8)
      $display("FAIL sw_lat: got %0d want 8",
               ret_log[1] - ret_log[0]);
    else n_pass++;
    n_checks++;
    if (ret_log[2] - ret_log[1] !== 9)
      $display("FAIL lw_lat: got %0d want 9",
               ret_log[2] - ret_log[1]);
    else n_pass++;
    n_checks++;
    if (viol !== 0)
      $display("FAIL req_stable: got %0d want 0", viol);
    else n_pass++;
  endtask

  task automatic test_control();
    bit ok;
    logic [31:0] exp [13];
    exp = '{32'h100, 32'h104, 32'h108, 32'h10C,
            32'h110, 32'h200, 32'h100, 32'h104,
            32'h108, 32'h10C, 32'h020, 32'h020,
            32'h020};
    start(0);
    load(32'h100, 32'h20E70001);
    load(32'h104, 32'h20060200);
    load(32'h108, 32'h20080002);
    load(32'h10C, 32'h10E8FFC4);
    load(32'h110, 32'h00C00008);
    load(32'h200, 32'h08000040);
    load(32'h020, 32'h1021FFFF);
    rst = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fetch_n >= 13) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (!ok)
      $display("FAIL ctl_timeout: got %0d fetches want 13",
               fetch_n);
    else n_pass++;
    for (int i = 0; i < 13; i++) begin
      n_checks++;
      if (fetch_log[i] !== exp[i])
        $display("FAIL ctl_fetch%0d: got %h want %h",
                 i, fetch_log[i], exp[i]);
      else n_pass++;
    end
    n_checks++;
    if (ret_n < 2 ||
        ret_log[ret_n - 1] - ret_log[ret_n - 2] !== 3)
      $display("FAIL beq_lat: got n=%0d want interval 3",
               ret_n);
    else n_pass++;
  endtask

  task automatic test_zero_reg();
    bit ok;
    start(0);
    load(32'h100, 32'h20000007);
    load(32'h104, 32'h00003820);
    load(32'h108, 32'hAC070300);
    load(32'h10C, 32'hAC000304);
    load(32'h110, 32'hFC000000);
    load(32'h300, 32'h0000DEAD);
    load(32'h304, 32'h0000BEEF);
    rst = 1'b0;
    run_until_halt(100, ok);
    n_checks++;
    if (!ok || mem[192] !== 32'd0)
      $display("FAIL zero_r7: got %h want 0", mem[192]);
    else n_pass++;
    n_checks++;
    if (mem[193] !== 32'd0)
      $display("FAIL zero_r0: got %h want 0", mem[193]);
    else n_pass++;
  endtask

  task automatic test_illegal_reset();
    bit ok, bad;
    int f0, w0;
    start(0);
    load(32'h100, 32'h20010009);
    load(32'h104, 32'hFC000000);
    rst = 1'b0;
    run_until_halt(50, ok);
    n_checks++;
    if (!ok) $display("FAIL ill_halt: got 0 want 1");
    else n_pass++;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (mem_req || retire || !halt) bad = 1'b1;
    end
    n_checks++;
    if (bad)
      $display("FAIL halt_sticky: got req/ret/halt wrong want 0/0/1");
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (halt !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL halt_clear: got halt=%b req=%b want 0 0",
               halt, mem_req);
    else n_pass++;
    wait_cfg = 5;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100)
      $display("FAIL fetch_wait: got req=%b addr=%h want 1 100",
               mem_req, mem_addr);
    else n_pass++;
    f0 = fetch_n;
    w0 = wr_n;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0)
      $display("FAIL mid_rst_req: got %b want 0", mem_req);
    else n_pass++;
    wait_cfg = 0;
    @(negedge clk);
    n_checks++;
    if (fetch_n !== f0)
      $display("FAIL mid_rst_commit: got %0d want %0d",
               fetch_n, f0);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (mem_addr !== 32'h100 || mem_req !== 1'b1)
      $display("FAIL rst_pc: got %h want 00000100",
               mem_addr);
    else n_pass++;
    run_until_halt(50, ok);
    n_checks++;
    if (!ok || wr_n !== w0)
      $display("FAIL rerun: got halt=%b wr=%0d want 1 %0d",
               ok, wr_n, w0);
    else n_pass++;
  endtask

  initial begin
    #1 rst = 1'b1;
    test_reset();
    test_alu();
    test_mem_wait();
    test_control();
    test_zero_reg();
    test_illegal_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
